// File: rtl/ccs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccs_pkg
//  Description : Shared types and constants for the CCS (Count, Compare,
//                Skip) sequencer and its classification datapath.
//                - ccs_state_t : sequencer states IDLE/FETCH/EVAL/WB
//                - ccs_class_t : operand classes POS/PZERO/NEG/NZERO
//                - SKIP_*      : PC skip amount per operand class
//                - ONES_NEG_ZERO : all-ones pattern (ones-complement -0),
//                                  sliced to the datapath width by users
//  Revision    : 1.0 - initial release
// ============================================================================
package ccs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EVAL  = 2'd2,
        ST_WB    = 2'd3
    } ccs_state_t;

    typedef enum logic [1:0] {
        CLS_POS   = 2'd0,
        CLS_PZERO = 2'd1,
        CLS_NEG   = 2'd2,
        CLS_NZERO = 2'd3
    } ccs_class_t;

    localparam int SKIP_W = 3;

    localparam logic [SKIP_W-1:0] SKIP_POS   = 3'd1;
    localparam logic [SKIP_W-1:0] SKIP_PZERO = 3'd2;
    localparam logic [SKIP_W-1:0] SKIP_NEG   = 3'd3;
    localparam logic [SKIP_W-1:0] SKIP_NZERO = 3'd4;

    // Wide enough for any practical datapath; users take the low DATA_W bits.
    localparam int ONES_MAX_W = 64;
    localparam logic [ONES_MAX_W-1:0] ONES_NEG_ZERO = '1;

endpackage : ccs_pkg
`default_nettype wire

// File: rtl/ccs_classify.sv
`default_nettype none
// ============================================================================
//  Module      : ccs_classify
//  Description : Purely combinational CCS classifier. Splits a
//                ones-complement operand into class, skip amount and
//                diminished absolute value (|X| - 1, floored at 0).
//  Ports       : x    in  DATA_W  operand (sign in MSB)
//                cls  out 2       operand class
//                skip out SKIP_W  PC skip amount (1..4)
//                dabs out DATA_W  diminished absolute value
//  Revision    : 1.0 - initial release
// ============================================================================
module ccs_classify
    import ccs_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] x,
    output ccs_class_t        cls,
    output logic [SKIP_W-1:0] skip,
    output logic [DATA_W-1:0] dabs
);

    localparam logic [DATA_W-1:0] NEG_ZERO = ONES_NEG_ZERO[DATA_W-1:0];
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    // Both zeros are tested before the sign bit so that -0 (all ones) is
    // never treated as an ordinary negative number.
    always_comb begin
        cls  = CLS_POS;
        skip = SKIP_POS;
        dabs = x - ONE;
        if (x == '0) begin
            cls  = CLS_PZERO;
            skip = SKIP_PZERO;
            dabs = '0;
        end else if (x == NEG_ZERO) begin
            cls  = CLS_NZERO;
            skip = SKIP_NZERO;
            dabs = '0;
        end else if (x[DATA_W-1]) begin
            cls  = CLS_NEG;
            skip = SKIP_NEG;
            dabs = (~x) - ONE;
        end
    end

endmodule : ccs_classify
`default_nettype wire

// File: rtl/ccs_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ccs_sequencer
//  Description : Multi-cycle controller for the CCS instruction: fetches the
//                operand, classifies it, writes the diminished absolute value
//                to A and advances the PC by the class-dependent skip.
//  Ports       : clk, reset_n (sync, active-low)
//                start / operand_addr / pc_in   request from decoder
//                busy / done / error            status to decoder
//                mem_req / mem_addr / mem_ack / mem_rdata   memory read port
//                a_we / a_wdata, pc_we / pc_wdata          register writes
//  Revision    : 1.0 - initial release
// ============================================================================
module ccs_sequencer
    import ccs_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int PC_W    = 12,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] operand_addr,
    input  logic [PC_W-1:0]   pc_in,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              a_we,
    output logic [DATA_W-1:0] a_wdata,
    output logic              pc_we,
    output logic [PC_W-1:0]   pc_wdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

    ccs_state_t        r_state;
    ccs_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_operand;
    logic [CNT_W-1:0]  r_cnt;
    ccs_class_t        r_cls;
    logic [SKIP_W-1:0] r_skip;
    logic [DATA_W-1:0] r_dabs;
    ccs_class_t        w_cls;
    logic [SKIP_W-1:0] w_skip;
    logic [DATA_W-1:0] w_dabs;
    logic              w_timeout;
    logic [PC_W-1:0]   w_pc_target;

    ccs_classify #(
        .DATA_W (DATA_W)
    ) u_classify (
        .x    (r_operand),
        .cls  (w_cls),
        .skip (w_skip),
        .dabs (w_dabs)
    );

    // An ack arriving in the last allowed cycle takes priority over timeout.
    assign w_timeout = (r_state == ST_FETCH) && !mem_ack && (r_cnt == CNT_LAST);

    // Fall-through keeps the PC as-is; other classes add skip-1 with wrap.
    assign w_pc_target = (r_cls == CLS_POS) ? r_pc
                                            : r_pc + PC_W'(r_skip) - PC_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack)        w_next = ST_EVAL;
                else if (w_timeout) w_next = ST_IDLE;
            end
            ST_EVAL:  w_next = ST_WB;
            ST_WB:    w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_pc      <= '0;
            r_operand <= '0;
            r_cnt     <= '0;
            r_cls     <= CLS_POS;
            r_skip    <= '0;
            r_dabs    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr <= operand_addr;
                        r_pc   <= pc_in;
                        r_cnt  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        r_operand <= mem_rdata;
                    end else if (r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_EVAL: begin
                    r_cls  <= w_cls;
                    r_skip <= w_skip;
                    r_dabs <= w_dabs;
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy     = (r_state != ST_IDLE);
        mem_req  = (r_state == ST_FETCH);
        mem_addr = (r_state == ST_FETCH) ? r_addr : '0;
        error    = w_timeout;
        done     = (r_state == ST_WB);
        a_we     = (r_state == ST_WB);
        pc_we    = (r_state == ST_WB);
        a_wdata  = (r_state == ST_WB) ? r_dabs : '0;
        pc_wdata = (r_state == ST_WB) ? w_pc_target : '0;
    end

endmodule : ccs_sequencer
`default_nettype wire

// File: tb/tb_ccs_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccs_sequencer
//  Description : Scoreboard bench for ccs_sequencer. A stimulus process
//                issues CCS instructions and pushes expected results computed
//                from the ones-complement rules; a memory responder acks
//                after a chosen delay (or never); a monitor pops and compares
//                whenever done or error is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccs_sequencer;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 12;
    localparam int PC_W    = 12;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] operand_addr = '0;
    logic [PC_W-1:0]   pc_in = '0;
    logic              busy, done, error, mem_req, a_we, pc_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] a_wdata;
    logic [PC_W-1:0]   pc_wdata;

    ccs_sequencer #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .PC_W (PC_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .reset_n (reset_n), .start (start),
        .operand_addr (operand_addr), .pc_in (pc_in),
        .busy (busy), .done (done), .error (error),
        .mem_req (mem_req), .mem_addr (mem_addr),
        .mem_ack (mem_ack), .mem_rdata (mem_rdata),
        .a_we (a_we), .a_wdata (a_wdata),
        .pc_we (pc_we), .pc_wdata (pc_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int a;
        int pc;
        int cycle;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    // Shared with the memory responder
    int              ack_delay = -1;
    logic [DATA_W-1:0] cur_operand = '0;
    logic [ADDR_W-1:0] cur_addr = '0;
    int              fetch_idx = 0;

    always @(posedge clk) cyc++;

    // Reference: classify by value, magnitude of a negative is all-ones minus X.
    function automatic void model(input int x, input int pc, output int dabs, output int npc);
        int skip;
        if (x == 0) begin
            skip = 2; dabs = 0;
        end else if (x == 'hFFFF) begin
            skip = 4; dabs = 0;
        end else if (x < 'h8000) begin
            skip = 1; dabs = x - 1;
        end else begin
            skip = 3; dabs = ('hFFFF - x) - 1;
        end
        npc = (pc + skip - 1) % (1 << PC_W);
    endfunction

    // Memory responder: ack on FETCH cycle index ack_delay (never if negative)
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (fetch_idx == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = cur_operand;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
            end
            fetch_idx++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            fetch_idx = 0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (a_we !== done || pc_we !== done || (done && error) ||
                mem_addr !== (mem_req ? cur_addr : '0)) begin
                failures++;
                $display("FAIL strobes cyc=%0d got a_we=%0b pc_we=%0b done=%0b error=%0b mem_addr=%h required a_we=pc_we=done, no done&error, mem_addr=%h",
                         cyc, a_we, pc_we, done, error, mem_addr, mem_req ? cur_addr : '0);
            end
            if (done || error) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp cyc=%0d got done=%0b error=%0b required none", cyc, done, error);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (error !== e.is_err || cyc != e.cycle) begin
                        failures++;
                        $display("FAIL kind_cycle got error=%0b cyc=%0d required error=%0b cyc=%0d",
                                 error, cyc, e.is_err, e.cycle);
                    end
                    if (!e.is_err && done) begin
                        checks++;
                        if (int'(a_wdata) != e.a || int'(pc_wdata) != e.pc) begin
                            failures++;
                            $display("FAIL writeback got a=%h pc=%h required a=%h pc=%h",
                                     a_wdata, pc_wdata, e.a[15:0], e.pc[11:0]);
                        end
                    end
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle; leaves at posedge+1 of the next cycle.
    task automatic launch(input int pc, input int x, input int delay, input bit junk);
        exp_t e;
        int   d, np;
        cur_addr     = ADDR_W'($urandom);
        cur_operand  = DATA_W'(x);
        ack_delay    = delay;
        operand_addr = cur_addr;
        pc_in        = PC_W'(pc);
        start        = 1'b1;
        model(x, pc, d, np);
        e.is_err = (delay < 0);
        e.a      = d;
        e.pc     = np;
        e.cycle  = e.is_err ? cyc + 1 + TIMEOUT : cyc + 3 + delay;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start        = 1'b0;
        operand_addr = ADDR_W'($urandom);
        pc_in        = PC_W'($urandom);
        if (junk && $urandom_range(0, 2) == 0) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 100) begin
            // A start during the done cycle must be ignored.
            if (done && $urandom_range(0, 1) == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_wait got busy=%0b required 0", busy);
        end
    endtask

    task automatic run(input int pc, input int x, input int delay);
        wait_idle();
        launch(pc, x, delay, 1'b1);
        wait_idle();
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({busy, done, error, mem_req, a_we, pc_we} !== 6'b0 ||
            mem_addr !== '0 || a_wdata !== '0 || pc_wdata !== '0) begin
            failures++;
            $display("FAIL %s got busy=%0b done=%0b error=%0b req=%0b a_we=%0b pc_we=%0b addr=%h a=%h pc=%h required all 0",
                     name, busy, done, error, mem_req, a_we, pc_we, mem_addr, a_wdata, pc_wdata);
        end
    endtask

    // Reset asserted `hold` cycles after the first FETCH cycle.
    task automatic reset_mid(input int delay, input int hold, input string name);
        wait_idle();
        launch(12'h0AB, 16'h1234, delay, 1'b0);
        repeat (hold) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_zero(name);
        repeat (4) @(posedge clk);
        #1;
    endtask

    function automatic int pick_operand();
        case ($urandom_range(0, 7))
            0: return 'h0000;
            1: return 'hFFFF;
            2: return 'h0001;
            3: return 'hFFFE;
            4: return 'h8000;
            5: return 'h7FFF;
            default: return int'($urandom_range(0, 'hFFFF));
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_zero("reset_state");
        @(posedge clk); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk); #1;

        run(12'h100, 16'h0005, 2);
        run(12'h200, 16'h0000, 0);
        run(12'h200, 16'hFFFF, 1);
        run(12'h300, 16'hFFFA, 0);
        run(12'h300, 16'hFFFE, 3);
        run(12'hFFF, 16'hFFFF, 0);
        run(12'hFFF, 16'h0003, 0);
        run(12'h123, 16'h0001, 0);
        run(12'h050, 16'h8000, 1);
        run(12'h050, 16'h7FFF, 0);
        run(12'h400, 16'h5555, -1);
        run(12'h400, 16'h0010, TIMEOUT);
        run(12'h401, 16'hFFF0, TIMEOUT - 1);

        reset_mid(-1, 1, "reset_in_fetch");
        reset_mid(0, 1, "reset_in_eval");

        for (int i = 0; i < 80; i++) begin
            int dly;
            dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TIMEOUT));
            run(int'($urandom_range(0, (1 << PC_W) - 1)), pick_operand(), dly);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_resp got %0d outstanding required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ccs_sequencer
`default_nettype wire

// File: doc/ccs_sequencer.md
Name: ccs_sequencer

Overview:
- Multi-cycle controller that executes the CCS (Count, Compare, Skip) instruction around the CCS classification/arithmetic datapath.
- On a start pulse it:
  - fetches the operand word over the memory handshake,
  - classifies the operand as +nonzero, +0, -nonzero or -0 (ones-complement, sign in bit 15),
  - writes the diminished absolute value to A,
  - advances the PC by the skip amount.
- Sits between the instruction decoder (start/done) and the register file / memory port.

Parameters:
- DATA_W, 16, operand/accumulator width; ones-complement, MSB is sign.
- ADDR_W, 12, memory address width.
- PC_W, 12, program counter width.
- TIMEOUT, 15, max cycles to wait for mem_ack before aborting; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to execute CCS; ignored unless idle.
- operand_addr  in  ADDR_W  operand address, sampled when start is accepted.
- pc_in  in  PC_W  current PC (already pointing at next instruction), sampled with start.
- busy  out  1  high from the cycle after start is accepted until done/error.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on memory timeout.
- mem_req  out  1  read request; held until mem_ack or timeout.
- mem_addr  out  ADDR_W  latched operand_addr while mem_req is high; 0 otherwise.
- mem_ack  in  1  read data valid.
- mem_rdata  in  DATA_W  read data, valid when mem_ack is high.
- a_we  out  1  A register write strobe.
- a_wdata  out  DATA_W  new A value.
- pc_we  out  1  PC write strobe.
- pc_wdata  out  PC_W  new PC value.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state = IDLE;
  - all outputs 0, all internal registers (operand, addr, pc, timeout counter) 0.
  - Reset mid-operation aborts immediately: no a_we/pc_we is issued for the aborted instruction.
- States: IDLE, FETCH, EVAL, WB.
- IDLE:
  - start=1 latches operand_addr and pc_in and moves to FETCH.
  - busy rises the next cycle.
- FETCH:
  - mem_req=1, mem_addr = latched address.
  - The timeout counter clears on entry and increments each cycle without mem_ack.
  - mem_ack=1: latch mem_rdata, drop mem_req the next cycle, go to EVAL.
  - Counter reaching TIMEOUT without ack: pulse error, go to IDLE, no writes.
  - mem_ack in the same cycle the counter hits TIMEOUT: the ack wins.
- EVAL (1 cycle), computed on the latched operand X:
  - X = 0x0000 (+0): skip=2, dabs=0.
  - X = 0xFFFF (-0): skip=4, dabs=0.
  - X[15]=0, nonzero: skip=1, dabs = X-1.
  - X[15]=1, not 0xFFFF: skip=3, dabs = (~X)-1.
  - Classification priority: the ±0 checks precede the sign check.
  - Magnitude 1 (0x0001 or 0xFFFE) yields dabs=0.
- WB (1 cycle):
  - a_we=1, a_wdata=dabs.
  - pc_we=1, pc_wdata = (pc + skip - 1) mod 2^PC_W; skip=1 means fall through, and pc wraps silently.
  - done=1.
  - Next state IDLE; busy drops the following cycle.
- Latency: ack in cycle N → done in cycle N+2. Minimum start-to-done is 4 cycles (ack in the first FETCH cycle).
- start while busy or in the done cycle is ignored; no queuing. Back-to-back start is accepted the cycle after done.
- a_we/pc_we/done are never high outside WB; error and done are never simultaneous.

Decomposition:
- Shared package (ccs_pkg):
  - state enum (IDLE/FETCH/EVAL/WB);
  - class enum (POS, PZERO, NEG, NZERO);
  - constants ONES_NEG_ZERO = all-ones, skip amounts SKIP_POS=1, SKIP_PZERO=2, SKIP_NEG=3, SKIP_NZERO=4.
- One sub-module, ccs_classify: purely combinational; X → {class, skip, dabs}; instantiated for EVAL and unit-testable alone.

Test Plan:
- pc_in=0x100, operand 0x0005, ack after 2 cycles → a_wdata=0x0004, pc_wdata=0x100, one done pulse.
- Operand 0x0000 → a_wdata=0x0000, pc_wdata=pc_in+1; operand 0xFFFF → a_wdata=0x0000, pc_wdata=pc_in+3.
- Operand 0xFFFA (-5) → a_wdata=0x0004, pc_wdata=pc_in+2; operand 0xFFFE (-1) → a_wdata=0x0000.
- pc_in=0xFFF, operand 0xFFFF → pc_wdata=0x002 (wrap); pc_in=0xFFF, operand 0x0003 → pc_wdata=0xFFF.
- mem_ack never asserted with TIMEOUT=15 → error pulses exactly TIMEOUT cycles after FETCH entry, no a_we/pc_we, busy clears; ack on the final timeout cycle → normal completion.
- reset_n low during FETCH and again during EVAL → outputs 0 next cycle, no writes; start pulsed while busy → ignored, exactly one done.
